// File: rtl/fnn_sample_server_if.sv
// rtl/fnn_sample_server_if.sv - input/label memory read port shared by the sample server and its memories
interface fnn_sample_server_if #(
  parameter int DATA_W  = 8,
  parameter int LABEL_W = 4,
  parameter int ADDR_W  = 10,
  parameter int MADDR_W = 16
);
  logic               mem_rd_en;
  logic [MADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic               lbl_rd_en;
  logic [ADDR_W-1:0]  lbl_addr;
  logic [LABEL_W-1:0] lbl_rdata;

  modport master (
    output mem_rd_en, mem_addr, lbl_rd_en, lbl_addr,
    input  mem_rdata, lbl_rdata
  );

  modport slave (
    input  mem_rd_en, mem_addr, lbl_rd_en, lbl_addr,
    output mem_rdata, lbl_rdata
  );
endinterface

// File: rtl/fnn_sample_server.sv
// rtl/fnn_sample_server.sv - fetches one sample's features and label per request; FNN_SAMPLE_WRAP_EN wraps the sample counter
module fnn_sample_server #(
  parameter int NUM_SAMPLES = 750,
  parameter int NUM_FEAT    = 62,
  parameter int DATA_W      = 8,
  parameter int LABEL_W     = 4,
  parameter int ADDR_W      = 10,
  parameter int MADDR_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         advance,
  fnn_sample_server_if.master          mem,
  output logic [NUM_FEAT*DATA_W-1:0]   feat_vec,
  output logic                         feat_valid,
  output logic [LABEL_W-1:0]           label,
  output logic [ADDR_W-1:0]            addr_cnt,
  output logic                         busy,
  output logic                         all_done
);
  localparam int K_W = $clog2(NUM_FEAT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, READY, DONE} state_t;

  state_t             state, state_nxt;
  logic [MADDR_W-1:0] base;
  logic [K_W-1:0]     k;
  logic [K_W-1:0]     rd_idx;
  logic               rd_pend;
  logic               lbl_pend;
  logic               last_word;
  logic               last_sample;
  logic               do_advance;

  assign last_word   = (k == K_W'(NUM_FEAT - 1));
  assign last_sample = (addr_cnt == ADDR_W'(NUM_SAMPLES - 1));
  assign do_advance  = (state == READY) && advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_rd_en = 1'b0;
    mem.mem_addr  = '0;
    mem.lbl_rd_en = 1'b0;
    mem.lbl_addr  = addr_cnt;
    case (state)
      IDLE: if (req) state_nxt = FETCH;
      FETCH: begin
        mem.mem_rd_en = 1'b1;
        mem.mem_addr  = base + MADDR_W'(k);
        mem.lbl_rd_en = (k == '0);
        if (last_word) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = READY;
      READY: begin
        if (advance) begin
`ifdef FNN_SAMPLE_WRAP_EN
          state_nxt = IDLE;
`else
          state_nxt = last_sample ? DONE : IDLE;
`endif
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory data lags its strobe by a cycle, so the slot index and label strobe ride one register behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= '0;
      k          <= '0;
      rd_idx     <= '0;
      rd_pend    <= 1'b0;
      lbl_pend   <= 1'b0;
      feat_vec   <= '0;
      feat_valid <= 1'b0;
      label      <= '0;
      addr_cnt   <= '0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      rd_pend  <= mem.mem_rd_en;
      rd_idx   <= k;
      lbl_pend <= mem.lbl_rd_en;
      if (rd_pend) begin
        for (int i = 0; i < NUM_FEAT; i++) begin
          if (rd_idx == K_W'(i)) feat_vec[i*DATA_W +: DATA_W] <= mem.mem_rdata;
        end
      end
      if (lbl_pend) label <= mem.lbl_rdata;
      if (state == IDLE && req) begin
        base <= MADDR_W'(addr_cnt) * MADDR_W'(NUM_FEAT);
        k    <= '0;
        busy <= 1'b1;
      end
      if (state == FETCH) k <= k + 1'b1;
      if (state == DRAIN) begin
        feat_valid <= 1'b1;
        busy       <= 1'b0;
      end
      if (do_advance) begin
        feat_valid <= 1'b0;
        if (!last_sample) addr_cnt <= addr_cnt + 1'b1;
`ifdef FNN_SAMPLE_WRAP_EN
        else addr_cnt <= '0;
`endif
      end
`ifdef FNN_SAMPLE_WRAP_EN
      all_done <= do_advance && last_sample;
`else
      if (do_advance && last_sample) all_done <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_fnn_sample_server.sv
// tb/tb_fnn_sample_server.sv - directed self-checking bench for fnn_sample_server (4 features, 3 samples)
module tb_fnn_sample_server;
  localparam int NF = 4;
  localparam int NS = 3;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AW = 10;
  localparam int MW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              advance;
  logic [NF*DW-1:0]  feat_vec;
  logic              feat_valid;
  logic [LW-1:0]     label;
  logic [AW-1:0]     addr_cnt;
  logic              busy;
  logic              all_done;

  int n_cmp = 0;
  int n_err = 0;
  int rd_count = 0;
  int lbl_count = 0;
  logic [MW-1:0] addr_log [0:255];

  fnn_sample_server_if #(.DATA_W(DW), .LABEL_W(LW), .ADDR_W(AW), .MADDR_W(MW)) mif ();

  fnn_sample_server #(
    .NUM_SAMPLES(NS), .NUM_FEAT(NF), .DATA_W(DW),
    .LABEL_W(LW), .ADDR_W(AW), .MADDR_W(MW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .advance(advance), .mem(mif),
    .feat_vec(feat_vec), .feat_valid(feat_valid), .label(label),
    .addr_cnt(addr_cnt), .busy(busy), .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Synchronous memories: word a holds a+0x10, label i holds i+1.
  always @(posedge clk) begin
    if (mif.mem_rd_en) mif.mem_rdata <= 8'(mif.mem_addr + 16'h10);
    if (mif.lbl_rd_en) mif.lbl_rdata <= 4'(mif.lbl_addr + 10'd1);
  end

  always @(negedge clk) begin
    if (mif.mem_rd_en) begin
      addr_log[8'(rd_count)] <= mif.mem_addr;
      rd_count <= rd_count + 1;
    end
    if (mif.lbl_rd_en) lbl_count <= lbl_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input bit hold, input logic [31:0] exp_vec, input logic [3:0] exp_lbl,
                          input logic [15:0] exp_base, input logic [9:0] exp_addr);
    int r0;
    int l0;
    int n;
    r0 = rd_count;
    l0 = lbl_count;
    req = 1'b1;
    cyc();
    if (!hold) req = 1'b0;
    chk("busy_start", busy, 1);
    n = 0;
    while (!feat_valid && n < 20) begin
      cyc();
      n++;
      if (hold) advance = (n == 1);
    end
    req = 1'b0;
    advance = 1'b0;
    chk("valid_latency", n, 5);
    chk("feat_vec", feat_vec, exp_vec);
    chk("label", label, exp_lbl);
    chk("busy_end", busy, 0);
    chk("addr_cnt", addr_cnt, exp_addr);
    chk("rd_cycles", rd_count - r0, 4);
    chk("lbl_cycles", lbl_count - l0, 1);
    for (int i = 0; i < 4; i++) chk("mem_addr_seq", addr_log[8'(r0 + i)], exp_base + 16'(i));
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    req = 1'b0;
    advance = 1'b0;
    cyc();
    cyc();
    chk("rst_feat_valid", feat_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_cnt", addr_cnt, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_feat_vec", feat_vec, 0);
    chk("rst_mem_rd_en", mif.mem_rd_en, 0);
    rst = 1'b0;
    cyc();

    do_fetch(1'b0, 32'h13121110, 4'd1, 16'd0, 10'd0);
    cyc();
    cyc();
    chk("ready_hold_valid", feat_valid, 1);
    chk("ready_hold_vec", feat_vec, 32'h13121110);

    // req and advance together in READY: advance wins, no fetch starts
    req = 1'b1;
    advance = 1'b1;
    cyc();
    req = 1'b0;
    advance = 1'b0;
    chk("both_addr_cnt", addr_cnt, 1);
    chk("both_feat_valid", feat_valid, 0);
    r0 = rd_count;
    cyc();
    cyc();
    cyc();
    chk("both_no_reads", rd_count - r0, 0);
    chk("both_busy", busy, 0);

    do_fetch(1'b0, 32'h17161514, 4'd2, 16'd4, 10'd1);
    advance = 1'b1;
    cyc();
    advance = 1'b0;
    chk("adv_addr_cnt", addr_cnt, 2);
    chk("adv_feat_valid", feat_valid, 0);

    // req held and advance pulsed during FETCH: both ignored
    do_fetch(1'b1, 32'h1B1A1918, 4'd3, 16'd8, 10'd2);

    advance = 1'b1;
    cyc();
    advance = 1'b0;
    chk("last_all_done", all_done, 1);
    chk("last_feat_valid", feat_valid, 0);
`ifdef FNN_SAMPLE_WRAP_EN
    chk("wrap_addr_cnt", addr_cnt, 0);
    cyc();
    chk("wrap_all_done_pulse", all_done, 0);
    do_fetch(1'b0, 32'h13121110, 4'd1, 16'd0, 10'd0);
`else
    chk("done_addr_cnt", addr_cnt, 2);
    r0 = rd_count;
    req = 1'b1;
    advance = 1'b1;
    repeat (5) cyc();
    req = 1'b0;
    advance = 1'b0;
    chk("done_no_reads", rd_count - r0, 0);
    chk("done_busy", busy, 0);
    chk("done_all_done", all_done, 1);
    chk("done_addr_hold", addr_cnt, 2);
`endif

    // reset asserted two cycles into a fetch
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    cyc();
    chk("mid_word0", feat_vec[7:0], 8'h10);
    chk("mid_rd_en", mif.mem_rd_en, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_feat_vec", feat_vec, 0);
    chk("async_busy", busy, 0);
    chk("async_addr_cnt", addr_cnt, 0);
    chk("async_label", label, 0);
    chk("async_mem_rd_en", mif.mem_rd_en, 0);
    chk("async_mem_addr", mif.mem_addr, 0);
    chk("async_all_done", all_done, 0);
    cyc();
    rst = 1'b0;
    cyc();
    do_fetch(1'b0, 32'h13121110, 4'd1, 16'd0, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
